vec_ex_mem_pipe: RTL and testbench

Parametrised EX→MEM pipeline stage for the vector datapath. It replaces the free-running EX/MEM register with a two-entry skid buffer. The stage adds a valid/ready handshake, flush-to-bubble, per-lane write masking and a saturating back-pressure counter. It sits between the scalar+vector ALU outputs and the memory-access stage and carries one scalar result plus LANES vector results per instruction.

---
 rtl/vec_ex_mem_pipe.sv | 157 +++++++++++++++
 tb/tb_vec_ex_mem_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_ex_mem_pipe.sv
// EX->MEM pipeline stage for the vector datapath: a two-entry skid buffer (main + skid)
// with valid/ready handshake, flush-to-bubble, per-lane write masking and a
// saturating back-pressure counter.
module vec_ex_mem_pipe #(
  parameter int unsigned       LANES       = 8,
  parameter int unsigned       LANE_W      = 32,
  parameter int unsigned       PC_W        = 16,
  parameter int unsigned       ADDR_W      = 5,
  parameter int unsigned       CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(2),
  parameter int unsigned       STALL_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [PC_W-1:0]         in_pc,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [LANE_W-1:0]       in_scalar,
  input  logic [LANE_W-1:0]       in_store,
  input  logic [LANES*LANE_W-1:0] in_lanes,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [PC_W-1:0]         out_pc,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [LANE_W-1:0]       out_scalar,
  output logic [LANE_W-1:0]       out_store,
  output logic [LANES*LANE_W-1:0] out_lanes,
  output logic [LANES-1:0]        out_mask,
  output logic [STALL_W-1:0]      stall_cnt,
  input  logic                    stall_clr
);

  typedef struct packed {
    logic [CTRL_W-1:0]       ctrl;
    logic [PC_W-1:0]         pc;
    logic [ADDR_W-1:0]       addr;
    logic [LANE_W-1:0]       scalar;
    logic [LANE_W-1:0]       store;
    logic [LANES*LANE_W-1:0] lanes;
    logic [LANES-1:0]        mask;
  } entry_t;

  // Encoding is {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept, pop;
  logic   [STALL_W-1:0] stall_q;

  // in_ready comes straight from the skid-valid flop, so no path from out_ready.
  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Build the incoming entry with masked-off lanes forced to zero.
  always_comb begin
    in_entry        = '0;
    in_entry.ctrl   = in_ctrl;
    in_entry.pc     = in_pc;
    in_entry.addr   = in_addr;
    in_entry.scalar = in_scalar;
    in_entry.store  = in_store;
    in_entry.mask   = in_mask;
    for (int k = 0; k < int'(LANES); k++) begin
      in_entry.lanes[k*LANE_W +: LANE_W] = in_mask[k] ? in_lanes[k*LANE_W +: LANE_W] : '0;
    end
  end

  // Next-state and entry movement; flush overrides everything and keeps payload.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d     = StEmpty;
      main_d.ctrl = CTRL_BUBBLE;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = in_entry;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = StFull;
            skid_d  = in_entry;
          end else if (pop) begin
            state_d     = StEmpty;
            main_d.ctrl = CTRL_BUBBLE;
          end
        end
        StFull: begin
          if (pop) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d     = StEmpty;
          main_d.ctrl = CTRL_BUBBLE;
        end
      endcase
    end
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      main_q.ctrl <= CTRL_BUBBLE;
      skid_q      <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Saturating back-pressure counter; clear beats increment, flush is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (stall_clr) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign out_ctrl   = main_q.ctrl;
  assign out_pc     = main_q.pc;
  assign out_addr   = main_q.addr;
  assign out_scalar = main_q.scalar;
  assign out_store  = main_q.store;
  assign out_lanes  = main_q.lanes;
  assign out_mask   = main_q.mask;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_vec_ex_mem_pipe.sv
// Scoreboard bench for vec_ex_mem_pipe (STALL_W=3 so saturation is reachable).
module tb_vec_ex_mem_pipe;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
  logic [7:0]   in_ctrl, out_ctrl;
  logic [15:0]  in_pc, out_pc;
  logic [4:0]   in_addr, out_addr;
  logic [31:0]  in_scalar, in_store, out_scalar, out_store;
  logic [255:0] in_lanes, out_lanes;
  logic [7:0]   in_mask, out_mask;
  logic [2:0]   stall_cnt;

  typedef struct packed {
    logic [7:0]   ctrl;
    logic [15:0]  pc;
    logic [4:0]   addr;
    logic [31:0]  scalar;
    logic [31:0]  store;
    logic [255:0] lanes;
    logic [7:0]   mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  vec_ex_mem_pipe #(.STALL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_addr(in_addr), .in_scalar(in_scalar),
    .in_store(in_store), .in_lanes(in_lanes), .in_mask(in_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc), .out_addr(out_addr),
    .out_scalar(out_scalar), .out_store(out_store), .out_lanes(out_lanes),
    .out_mask(out_mask), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  // Monitor: a pop happens on the next rising edge; compare against the oldest expected.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h, required no output", out_pc);
      end else begin
        e = q.pop_front();
        if ({out_ctrl, out_pc, out_addr, out_scalar, out_store, out_lanes, out_mask} !== e) begin
          errors++;
          $display("FAIL sb_entry: got pc=%h ctrl=%h lanes=%h mask=%h, required pc=%h ctrl=%h lanes=%h mask=%h",
                   out_pc, out_ctrl, out_lanes, out_mask, e.pc, e.ctrl, e.lanes, e.mask);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Present one instruction for one cycle; record it if the stage is ready.
  task automatic drive(input logic [15:0] pc, input logic [7:0] mask,
                       input logic [31:0] base, input logic [31:0] step);
    exp_t e;
    in_valid  = 1'b1;
    in_pc     = pc;
    in_ctrl   = pc[7:0] ^ 8'hC1;
    in_addr   = pc[6:2];
    in_scalar = {16'h5CA1, pc};
    in_store  = {16'h5707, pc};
    in_mask   = mask;
    for (int k = 0; k < 8; k++) in_lanes[k*32 +: 32] = base + step * k;
    @(negedge clk);
    if (in_ready) begin
      e.ctrl = in_ctrl; e.pc = pc; e.addr = in_addr; e.scalar = in_scalar;
      e.store = in_store; e.mask = mask;
      for (int k = 0; k < 8; k++) e.lanes[k*32 +: 32] = mask[k] ? base + step * k : 32'h0;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, out_ctrl, stall_cnt} !== {1'b0, 1'b1, 8'h02, 3'd0}) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b ctrl=%h stall=%0d, required 0 1 02 0",
               out_valid, in_ready, out_ctrl, stall_cnt);
    end
    checks++;
    if ({out_pc, out_addr, out_scalar, out_store, out_lanes, out_mask} !== '0) begin
      errors++;
      $display("FAIL reset_payload: got pc=%h scalar=%h lanes=%h, required all zero",
               out_pc, out_scalar, out_lanes);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [15:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 16'h10 + 16'(4 * i);
      drive(pc, 8'hFF, 32'h1000_0000 * i, 32'h11);
      checks++;
      if (!out_valid || out_pc !== pc) begin
        errors++;
        $display("FAIL stream_pc%0d: got valid=%b pc=%h, required 1 %h", i, out_valid, out_pc, pc);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h02 || stall_cnt !== 3'd0) begin
      errors++;
      $display("FAIL stream_end: got valid=%b ctrl=%h stall=%0d, required 0 02 0",
               out_valid, out_ctrl, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(16'h0A00, 8'hFF, 32'hA000_0000, 32'h3);
    checks++;
    if (out_pc !== 16'h0A00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_one: got pc=%h ready=%b, required 0a00 1", out_pc, in_ready);
    end
    drive(16'h0B00, 8'h0F, 32'hB000_0000, 32'h5);
    checks++;
    if (out_pc !== 16'h0A00 || in_ready !== 1'b0 || !out_valid) begin
      errors++;
      $display("FAIL bp_full: got pc=%h ready=%b valid=%b, required 0a00 0 1",
               out_pc, in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_pc !== 16'h0B00 || in_ready !== 1'b1 || !out_valid) begin
      errors++;
      $display("FAIL bp_pop_a: got pc=%h ready=%b valid=%b, required 0b00 1 1",
               out_pc, in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h02 || stall_cnt !== 3'd4) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b ctrl=%h stall=%0d, required 0 02 4",
               out_valid, out_ctrl, stall_cnt);
    end
  endtask

  task automatic test_mask();
    logic [31:0] exp_lane;
    out_ready = 1'b1;
    drive(16'h0040, 8'b1010_0101, 32'hDEAD_BEEF, 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp_lane = (k == 1 || k == 3 || k == 4 || k == 6) ? 32'h0 : 32'hDEAD_BEEF;
      checks++;
      if (out_lanes[k*32 +: 32] !== exp_lane) begin
        errors++;
        $display("FAIL mask_lane%0d: got %h, required %h", k, out_lanes[k*32 +: 32], exp_lane);
      end
    end
    checks++;
    if (out_mask !== 8'hA5) begin
      errors++;
      $display("FAIL mask_out: got %h, required a5", out_mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(16'h0C00, 8'hFF, 32'h1, 32'h1);
    drive(16'h0D00, 8'hFF, 32'h2, 32'h1);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 16'h0E00;
    q.delete();
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h02 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got valid=%b ctrl=%h ready=%b, required 0 02 1",
               out_valid, out_ctrl, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet%0d: got valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_reset_in_full();
    out_ready = 1'b0;
    stall_clr = 1'b1;
    @(posedge clk); #1;
    stall_clr = 1'b0;
    drive(16'h0F00, 8'hFF, 32'h7, 32'h1);
    drive(16'h0F04, 8'hFF, 32'h8, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 3'd5 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstfull_pre: got stall=%0d ready=%b, required 5 0", stall_cnt, in_ready);
    end
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, out_ctrl, stall_cnt} !== {1'b0, 1'b1, 8'h02, 3'd0} ||
        {out_pc, out_addr, out_scalar, out_store, out_lanes, out_mask} !== '0) begin
      errors++;
      $display("FAIL rstfull_post: got valid=%b ready=%b ctrl=%h stall=%0d pc=%h, required 0 1 02 0 0",
               out_valid, in_ready, out_ctrl, stall_cnt, out_pc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    drive(16'h1100, 8'hFF, 32'h9, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 3'd7) begin
      errors++;
      $display("FAIL sat_hold: got %0d, required 7", stall_cnt);
    end
    stall_clr = 1'b1;
    @(posedge clk); #1;
    stall_clr = 1'b0;
    checks++;
    if (stall_cnt !== 3'd0) begin
      errors++;
      $display("FAIL sat_clr: got %0d, required 0", stall_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 3'd1) begin
      errors++;
      $display("FAIL sat_resume: got %0d, required 1", stall_cnt);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL sat_drain: got valid=%b pending=%0d, required 0 0", out_valid, q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
    in_ctrl = '0; in_pc = '0; in_addr = '0; in_scalar = '0; in_store = '0;
    in_lanes = '0; in_mask = '0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_mask();
    test_flush();
    test_reset_in_full();
    test_saturation();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
